// File: rtl/step_ctrl.sv
`default_nettype none
// ============================================================================
// step_ctrl : snake step pacing and steering controller
// Revision  : 1.0
// ============================================================================
module step_ctrl #(
    parameter logic [23:0] TICK_BASE   = 24'd5_000_000,
    parameter logic [23:0] TICK_DEC    = 24'd250_000,
    parameter logic [23:0] TICK_MIN    = 24'd1_000_000,
    parameter logic [15:0] DEB_CYCLES  = 16'd50_000,
    parameter int          LEVEL_SHIFT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic [9:0] length,
    input  logic       bite_self,
    output logic       vld,
    output logic [3:0] way,
    output logic [3:0] level,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_COUNT  = 3'd1,
        S_COMMIT = 3'd2,
        S_STEP   = 3'd3,
        S_DEAD   = 3'd4
    } state_t;

    localparam logic [15:0] DEB_LAST  = DEB_CYCLES - 16'd1;
    localparam logic [3:0]  DIR_RIGHT = 4'b1000;

    state_t      state, state_next;
    logic [3:0]  sync1, sync2, deb, hit, press, sel;
    logic        press_any;
    logic [23:0] tick_cnt, period;
    logic [3:0]  q0, q1, ref_dir, ref_opp;
    logic [1:0]  q_cnt;
    logic [3:0]  len_level;
    logic [23:0] len_period;
    logic        first_load, reload, pop, push, commit, flush, queue_en, sample_len;

    function automatic logic [3:0] calc_level(input logic [9:0] len);
        logic [9:0] sh;
        sh = len >> LEVEL_SHIFT;
        return (sh > 10'd15) ? 4'd15 : sh[3:0];
    endfunction

    // Subtraction is clamped at zero before the floor so a large level never wraps.
    function automatic logic [23:0] calc_period(input logic [3:0] lv);
        logic [27:0] dec;
        logic [23:0] rem;
        dec = {24'd0, lv} * {4'd0, TICK_DEC};
        if (dec >= {4'd0, TICK_BASE})
            rem = 24'd0;
        else
            rem = TICK_BASE - dec[23:0];
        return (rem < TICK_MIN) ? TICK_MIN : rem;
    endfunction

    assign len_level  = calc_level(length);
    assign len_period = calc_period(len_level);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 4'd0;
            sync2 <= 4'd0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_deb
        logic [15:0] cnt;
        logic        bit_q;

        // hit marks the sample that completes a run of DEB_CYCLES mismatches
        assign hit[i]   = (sync2[i] != bit_q) && (cnt == DEB_LAST);
        assign press[i] = hit[i] && sync2[i];
        assign deb[i]   = bit_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt   <= 16'd0;
                bit_q <= 1'b0;
            end else if (sync2[i] == bit_q) begin
                cnt <= 16'd0;
            end else if (hit[i]) begin
                cnt   <= 16'd0;
                bit_q <= sync2[i];
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    always_comb begin
        sel = 4'b0000;
        if (press[3])      sel = 4'b1000;
        else if (press[2]) sel = 4'b0100;
        else if (press[1]) sel = 4'b0010;
        else if (press[0]) sel = 4'b0001;
    end

    assign press_any = |press;

    // Tail before and after a pop is the same direction, so one reference serves both.
    assign ref_dir = (q_cnt == 2'd2) ? q1 : ((q_cnt == 2'd1) ? q0 : way);
    assign ref_opp = {ref_dir[2], ref_dir[3], ref_dir[0], ref_dir[1]};
    assign push    = queue_en && press_any && (sel != ref_dir) && (sel != ref_opp)
                     && ((q_cnt != 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        vld        = 1'b0;
        first_load = 1'b0;
        reload     = 1'b0;
        pop        = 1'b0;
        commit     = 1'b0;
        flush      = 1'b0;
        queue_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (press_any) begin
                    first_load = 1'b1;
                    state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                queue_en = 1'b1;
                if (tick_cnt == 24'd0)
                    state_next = S_COMMIT;
            end
            S_COMMIT: begin
                queue_en   = 1'b1;
                commit     = 1'b1;
                pop        = (q_cnt != 2'd0);
                state_next = S_STEP;
            end
            S_STEP: begin
                queue_en   = 1'b1;
                vld        = 1'b1;
                reload     = 1'b1;
                state_next = S_COUNT;
            end
            S_DEAD: begin
                flush = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (bite_self) begin
            state_next = S_DEAD;
            vld        = 1'b0;
            first_load = 1'b0;
            reload     = 1'b0;
            pop        = 1'b0;
            commit     = 1'b0;
            queue_en   = 1'b0;
            flush      = 1'b1;
        end
    end

    assign sample_len = ((state == S_IDLE) && !bite_self) || commit;
    assign game_over  = (state == S_DEAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= 24'd0;
            period   <= 24'd0;
            level    <= 4'd0;
            way      <= DIR_RIGHT;
            q0       <= 4'd0;
            q1       <= 4'd0;
            q_cnt    <= 2'd0;
        end else begin
            if (first_load)
                tick_cnt <= len_period - 24'd1;
            else if (reload)
                tick_cnt <= period - 24'd1;
            else if ((state == S_COUNT) && (tick_cnt != 24'd0))
                tick_cnt <= tick_cnt - 24'd1;

            if (sample_len) begin
                level  <= len_level;
                period <= len_period;
            end

            if (first_load)
                way <= sel;
            else if (pop)
                way <= q0;

            if (flush) begin
                q_cnt <= 2'd0;
            end else begin
                case ({pop, push})
                    2'b10: begin
                        q0    <= q1;
                        q_cnt <= q_cnt - 2'd1;
                    end
                    2'b01: begin
                        if (q_cnt == 2'd0)
                            q0 <= sel;
                        else
                            q1 <= sel;
                        q_cnt <= q_cnt + 2'd1;
                    end
                    2'b11: begin
                        if (q_cnt == 2'd2) begin
                            q0 <= q1;
                            q1 <= sel;
                        end else begin
                            q0 <= sel;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/step_ctrl.md
# step_ctrl

Movement pacing and steering controller for the snake game. It conditions the four direction buttons, queues legal turns, and issues the one-cycle `vld` step strobe together with a stable one-hot `way` to the snake movement stage. The step period shortens as the snake grows. All stepping stops permanently once a self-bite is reported.

## Interface

**Parameters**
- `TICK_BASE`, default 24'd5_000_000: step period P in cycles at level 0.
- `TICK_DEC`, default 24'd250_000: amount P shrinks per level.
- `TICK_MIN`, default 24'd1_000_000: floor on P.
- `DEB_CYCLES`, default 16'd50_000: number of stable samples a button needs before it is accepted.
- `LEVEL_SHIFT`, default 2: level = `length >> LEVEL_SHIFT`, saturated at 15.

**Ports** (clock and reset first)
- `clk` input 1: single system clock.
- `rst` input 1: synchronous, active-high reset.
- `btn` input 4: raw, asynchronous, active-high buttons. Bit 3 RIGHT, bit 2 LEFT, bit 1 UP, bit 0 DOWN.
- `length` input 10: current snake length.
- `bite_self` input 1: sticky self-collision flag from the movement stage.
- `vld` output 1: one-cycle step strobe.
- `way` output 4: one-hot direction, same bit order as `btn`.
- `level` output 4: current speed level.
- `game_over` output 1: sticky; set after a self-bite.

## Operation

**Button conditioning**
- Each `btn` bit passes through a 2-FF synchronizer.
- A per-bit counter updates the debounced bit only after DEB_CYCLES consecutive post-sync samples that differ from the current debounced value. Any mismatch restarts the count.
- A press is a 0→1 transition of a debounced bit.
- Simultaneous presses: only one is taken, priority RIGHT > LEFT > UP > DOWN. The others are dropped.

**Turn queue (2-entry FIFO)**
- Reference direction R is the tail entry if the queue is non-empty, otherwise `way`.
- A press equal to R or opposite to R is discarded.
- A press arriving while the queue is full is discarded; existing entries are never overwritten.

**State machine** (IDLE, COUNT, COMMIT, STEP, DEAD)
- IDLE: wait for the first press. It loads `way` directly with no reversal check, and the queue stays empty. Then go to COUNT.
- COUNT: counter runs P cycles (P-1 down to 0), then go to COMMIT.
- COMMIT (1 cycle):
  - If the queue is non-empty, pop the head into `way`.
  - Latch `level` and compute the next P = max(TICK_BASE − level·TICK_DEC, TICK_MIN). The arithmetic is 24-bit; the subtraction is clamped and must not underflow.
- STEP (1 cycle): `vld`=1, then return to COUNT.
- DEAD: entered from any state when `bite_self`=1, with priority over every other transition.
  - `vld`=0, queue flushed, `game_over`=1.
  - Exit only through `rst`.

**Other rules**
- A press and a pop in the same cycle: the pop happens first and the push uses the post-pop tail. A full queue therefore accepts the press in that cycle.
- `level` is initialised in IDLE from `length`, using the same formula as COMMIT.

## Timing
- Reset values: `vld`=0, `way`=4'b1000, `level`=0, `game_over`=0, state IDLE, queue empty, debounced bits 0, all counters 0.
- A mid-operation `rst` returns to these values on the next edge. A strobe pending in COMMIT is cancelled.
- `way` changes only in IDLE (first press) or COMMIT. It is therefore stable for at least one full cycle before and during every `vld`.
- Consecutive `vld` pulses are spaced exactly P+2 cycles apart. P is the value computed at the preceding COMMIT; the first interval uses the P from IDLE.
- The first `vld` comes P+2 cycles after the IDLE press cycle.
- Press latency: 2 (sync) + DEB_CYCLES cycles from a stable `btn` edge to queue entry.
- `bite_self` in COMMIT or STEP: `vld` must not assert in that cycle or any later one. `game_over` rises on the next edge.
- `length` is sampled only in IDLE and COMMIT; changes inside COUNT take effect at the next COMMIT.

## Test plan

All tests use TICK_BASE=20, TICK_DEC=4, TICK_MIN=8, DEB_CYCLES=3, LEVEL_SHIFT=2.

- **Reset and start:** hold `rst`, release, apply no buttons for 200 cycles → `vld` never asserts, `way`=4'b1000. Then press UP → `way`=4'b0010 and the first `vld` comes 22 cycles after the press is accepted.
- **Bounce:** toggle RIGHT every cycle for 10 cycles, then hold it → exactly one press is accepted, 5 cycles after it becomes stable.
- **Reversal and queue:**
  - With `way`=RIGHT, press LEFT → discarded.
  - Then press UP, then LEFT, then DOWN, all inside one COUNT → queue holds UP, LEFT; DOWN is dropped.
  - The next two `vld` pulses carry `way`=0010, then 0100.
- **Speed:**
  - `length`=8 → level 2, P=12, `vld` spacing 14.
  - `length`=40 → level 10, P clamped to 8, spacing 10.
  - `length`=1023 → level 15, spacing 10.
- **Game over:** assert `bite_self` for one cycle while in COMMIT → no `vld` in that STEP slot, `game_over`=1 on the next edge, no `vld` for the next 500 cycles, and button presses are ignored.
- **Reset mid-run:** assert `rst` during COUNT with 2 entries queued → all outputs return to reset values, the queue is empty, and the state is IDLE.
